uart_cmd_mirror: RTL and testbench

Parametrised UART command endpoint with echo. It receives 8N1 frames on RX, decodes ASCII digit commands into per-channel LED toggles, and mirrors every valid byte back on TX through a small FIFO. It sits directly behind the board UART pins in the top level. It replaces the fixed 5-LED, fixed-baud mirror with configurable baud divisor, channel count, echo depth and LED polarity, plus error reporting.

---
 rtl/uart_cmd_mirror.sv | 181 ++++++++++++++++++
 tb/tb_uart_cmd_mirror.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_mirror.sv
// uart_cmd_mirror: 8N1 UART receiver that turns ASCII digit commands into LED toggles and echoes valid bytes via a FIFO.
module uart_cmd_mirror #(
    parameter int CLKS_PER_BIT   = 104,
    parameter int NUM_LEDS       = 5,
    parameter bit ECHO           = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter bit LED_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                RX,
    output logic                TX,
    output logic [NUM_LEDS-1:0] leds,
    output logic                rx_valid,
    output logic [7:0]          rx_data,
    output logic                frame_err,
    output logic                overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LEN = 16'(CLKS_PER_BIT);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
    localparam logic [AW-1:0] P1 = 1;
    localparam logic [AW:0] C1 = 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    logic                rx_meta, rx_s;
    rx_state_t           rs, rs_n;
    logic [15:0]         rcnt, rcnt_n;
    logic [2:0]          rbit, rbit_n;
    logic [7:0]          rsh, rsh_n;
    logic                stop_ok, stop_bad;
    logic [NUM_LEDS-1:0] ch, ch_n;

    tx_state_t           ts, ts_n;
    logic [15:0]         tcnt, tcnt_n;
    logic [2:0]          tbit, tbit_n;
    logic [7:0]          tsh, tsh_n;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wr, rd;
    logic [AW:0]         cnt;
    logic                full, pop, push_req, push;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) {rx_meta, rx_s} <= 2'b11;
        else {rx_meta, rx_s} <= {RX, rx_meta};

    // The half-bit sample in START both rejects glitches and centres every later sample.
    always_comb begin
        rs_n = rs;
        rcnt_n = rcnt + 16'd1;
        rbit_n = rbit;
        rsh_n = rsh;
        stop_ok = 1'b0;
        stop_bad = 1'b0;
        case (rs)
            R_IDLE: begin
                rcnt_n = 16'd1;
                if (!rx_s) rs_n = R_START;
            end
            R_START: if (rcnt == HALF) begin
                rcnt_n = 16'd1;
                rbit_n = 3'd0;
                rs_n = rx_s ? R_IDLE : R_DATA;
            end
            R_DATA: if (rcnt == BIT_LEN) begin
                rcnt_n = 16'd1;
                rsh_n = {rx_s, rsh[7:1]};
                rbit_n = rbit + 3'd1;
                if (rbit == 3'd7) rs_n = R_STOP;
            end
            R_STOP: if (rcnt == BIT_LEN) begin
                stop_ok = rx_s;
                stop_bad = !rx_s;
                rs_n = rx_s ? R_IDLE : R_WAIT;
            end
            R_WAIT: if (rx_s) rs_n = R_IDLE;
            default: rs_n = R_IDLE;
        endcase
    end

    always_comb begin
        ch_n = ch;
        for (int i = 0; i < NUM_LEDS; i++)
            if (rsh == 8'(8'h31 + i)) ch_n[i] = ~ch[i];
        if (rsh == 8'h30) ch_n = '0;
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            rs <= R_IDLE;
            rcnt <= '0;
            rbit <= '0;
            rsh <= '0;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
            rx_data <= '0;
            ch <= '0;
        end else begin
            rs <= rs_n;
            rcnt <= rcnt_n;
            rbit <= rbit_n;
            rsh <= rsh_n;
            rx_valid <= stop_ok;
            frame_err <= stop_bad;
            if (stop_ok) rx_data <= rsh;
            if (stop_ok) ch <= ch_n;
        end

    assign leds = LED_ACTIVE_LOW ? ~ch : ch;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds then.
    assign full = cnt == FULL;
    assign pop = (ts == T_IDLE) && (cnt != '0);
    assign push_req = ECHO && rx_valid;
    assign push = push_req && (!full || pop);

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            wr <= '0;
            rd <= '0;
            cnt <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_req && full && !pop;
            if (push) wr <= wr + P1;
            if (pop) rd <= rd + P1;
            if (push && !pop) cnt <= cnt + C1;
            else if (pop && !push) cnt <= cnt - C1;
        end

    always_ff @(posedge clk)
        if (push) mem[wr] <= rx_data;

    always_comb begin
        ts_n = ts;
        tcnt_n = tcnt + 16'd1;
        tbit_n = tbit;
        tsh_n = tsh;
        case (ts)
            T_IDLE: begin
                tcnt_n = 16'd1;
                if (pop) begin
                    ts_n = T_START;
                    tsh_n = mem[rd];
                end
            end
            T_START: if (tcnt == BIT_LEN) begin
                tcnt_n = 16'd1;
                tbit_n = 3'd0;
                ts_n = T_DATA;
            end
            T_DATA: if (tcnt == BIT_LEN) begin
                tcnt_n = 16'd1;
                tsh_n = {1'b0, tsh[7:1]};
                tbit_n = tbit + 3'd1;
                if (tbit == 3'd7) ts_n = T_STOP;
            end
            T_STOP: if (tcnt == BIT_LEN) ts_n = T_IDLE;
            default: ts_n = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            ts <= T_IDLE;
            tcnt <= '0;
            tbit <= '0;
            tsh <= '0;
        end else begin
            ts <= ts_n;
            tcnt <= tcnt_n;
            tbit <= tbit_n;
            tsh <= tsh_n;
        end

    assign TX = (ts == T_START) ? 1'b0 : (ts == T_DATA) ? tsh[0] : 1'b1;
endmodule

// File: tb/tb_uart_cmd_mirror.sv
// tb_uart_cmd_mirror: randomized 8N1 traffic checked every cycle against an event-level model of receive, decode and echo.
module tb_uart_cmd_mirror;
    localparam int CPB = 8;
    localparam int H = CPB / 2;
    localparam int NL = 5;
    localparam int DEPTH = 2;
    localparam int FL = 10 * CPB;

    typedef struct {int v; logic [7:0] b; bit err;} rx_ev_t;
    typedef struct {int pop; logic [7:0] b;} tx_fr_t;

    logic clk = 1'b0, resetn = 1'b0, RX = 1'b1;
    logic TX, rx_valid, frame_err, overflow;
    logic [NL-1:0] leds;
    logic [7:0] rx_data;

    int total = 0, bad = 0, cyc = 0;
    int nvalid = 0, nfe = 0, novf = 0;
    rx_ev_t evq[$];
    tx_fr_t frq[$];
    int ovfq[$];
    logic [NL-1:0] ch_m = '0;
    logic [7:0] data_m = '0;
    int last_pop = -100000;

    uart_cmd_mirror #(.CLKS_PER_BIT(CPB), .NUM_LEDS(NL), .ECHO(1'b1), .FIFO_DEPTH(DEPTH), .LED_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .resetn(resetn), .RX(RX), .TX(TX), .leds(leds),
        .rx_valid(rx_valid), .rx_data(rx_data), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Rx valid/error pulse lands 3+H+9*CPB cycles after the start bit is driven (2 sync flops + registered pulse).
    task automatic send(input logic [7:0] b, input bit bad_stop, input int stop_len);
        evq.push_back(rx_ev_t'{cyc + 3 + H + 9 * CPB, b, bad_stop});
        RX = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            hold(CPB);
        end
        RX = !bad_stop;
        hold(stop_len);
        if (bad_stop) begin
            RX = 1'b1;
            hold(2 * CPB);
        end
    endtask

    task automatic glitch(input int g);
        RX = 1'b0;
        hold(g);
        RX = 1'b1;
        hold(H + 3);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        hold(2);
        chk("rst_tx", TX, 1);
        chk("rst_leds", leds, 5'b11111);
        chk("rst_rxdata", rx_data, 0);
        resetn = 1'b1;
        hold(4);
    endtask

    always @(negedge clk) begin
        logic ev_v, ev_fe, ev_ov, ev_tx;
        logic [NL-1:0] lm;
        int occ, pt, bi;
        rx_ev_t e;
        ev_v = 1'b0;
        ev_fe = 1'b0;
        ev_ov = 1'b0;
        ev_tx = 1'b1;
        if (!resetn) begin
            evq.delete();
            frq.delete();
            ovfq.delete();
            ch_m = '0;
            data_m = '0;
            last_pop = -100000;
        end else begin
            if (evq.size() > 0 && evq[0].v == cyc) begin
                e = evq.pop_front();
                if (e.err) ev_fe = 1'b1;
                else begin
                    ev_v = 1'b1;
                    data_m = e.b;
                    if (e.b == 8'h30) ch_m = '0;
                    else if (e.b >= 8'h31 && e.b < 8'(8'h31 + NL)) ch_m = ch_m ^ (NL'(1) << (e.b - 8'h31));
                    occ = 0;
                    foreach (frq[i]) if (frq[i].pop > cyc) occ++;
                    if (occ >= DEPTH) ovfq.push_back(cyc + 1);
                    else begin
                        pt = (last_pop + FL + 1 > cyc + 1) ? last_pop + FL + 1 : cyc + 1;
                        frq.push_back(tx_fr_t'{pt, e.b});
                        last_pop = pt;
                    end
                end
            end
            if (ovfq.size() > 0 && ovfq[0] == cyc) begin
                ev_ov = 1'b1;
                void'(ovfq.pop_front());
            end
            while (frq.size() > 0 && frq[0].pop + FL < cyc) void'(frq.pop_front());
            if (frq.size() > 0 && cyc > frq[0].pop) begin
                bi = (cyc - frq[0].pop - 1) / CPB;
                ev_tx = (bi == 0) ? 1'b0 : (bi < 9) ? frq[0].b[3'(bi - 1)] : 1'b1;
            end
        end
        lm = ~ch_m;
        chk("TX", TX, ev_tx);
        chk("leds", leds, lm);
        chk("rx_valid", rx_valid, ev_v);
        chk("rx_data", rx_data, data_m);
        chk("frame_err", frame_err, ev_fe);
        chk("overflow", overflow, ev_ov);
        if (rx_valid) nvalid++;
        if (frame_err) nfe++;
        if (overflow) novf++;
    end

    initial begin
        int r, v0, f0;
        logic [7:0] b;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        hold(4);
        send(8'h31, 0, CPB);
        send(8'h33, 0, CPB);
        send(8'h35, 0, CPB);
        hold(4 * FL);
        chk("lit_leds_135", leds, 5'b01010);
        chk("lit_rxdata_35", rx_data, 8'h35);
        chk("lit_nvalid_3", nvalid, 3);
        for (int i = 0; i < 6; i++) send((i == 5) ? 8'h30 : 8'(8'h31 + i), 0, H + 1);
        hold(8 * FL);
        chk("lit_leds_clear", leds, 5'b11111);
        chk("lit_nvalid_9", nvalid, 9);
        send(8'h32, 1, H + 1);
        hold(CPB);
        chk("lit_fe_1", nfe, 1);
        chk("lit_leds_after_fe", leds, 5'b11111);
        send(8'h32, 0, CPB);
        hold(2 * FL);
        chk("lit_leds_ch1", leds, 5'b11101);
        v0 = nvalid;
        f0 = nfe;
        glitch(3);
        hold(2 * FL);
        chk("lit_glitch_nvalid", nvalid, v0);
        chk("lit_glitch_fe", nfe, f0);
        send(8'h33, 0, CPB);
        hold(30);
        do_reset();
        send(8'h34, 0, CPB);
        hold(2 * FL);
        chk("lit_leds_ch3", leds, 5'b10111);
        for (int i = 0; i < 80; i++) send(8'($urandom), 0, H + 1);
        hold(4 * FL);
        chk("burst_overflow_seen", novf > 0, 1);
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            b = ($urandom_range(0, 1) == 1) ? 8'(8'h30 + $urandom_range(0, 9)) : 8'($urandom);
            if (i == 75) begin
                hold(20 + $urandom_range(0, 40));
                do_reset();
            end
            if (r == 0) glitch($urandom_range(1, H));
            else if (r == 1) send(b, 1, H + 1 + $urandom_range(0, CPB));
            else send(b, 0, ($urandom_range(0, 3) == 0) ? H + 1 + $urandom_range(0, 2 * CPB) : H + 1);
        end
        hold(6 * FL);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
